// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - nibble-serial W-bit adder with valid/ready handshakes
// Optional SUBTRACT_EN adds a 'sub' input selecting A + ~B + 1.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SUBTRACT_EN
  input  logic                 sub,
`endif
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  state_t          state_next;
  logic            armed;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    res_q;
  logic [W-1:0]    res_next;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            inv_q;
  logic            sub_sel;
  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [3:0]      nib_s;
  logic            nib_c;
  logic            last;
  logic            accept;

`ifdef SUBTRACT_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign last   = (idx == IW'(NIBBLES - 1));
  assign accept = in_valid & in_ready;

  // armed keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) & armed;
    out_valid = (state == DONE);
    busy      = (state == RUN) | (state == DONE);
  end

  // one 4-bit ripple slice, selected by the current nibble index
  always_comb begin
    nib_a = a_q[{idx, 2'b00} +: 4];
    nib_b = b_q[{idx, 2'b00} +: 4] ^ {4{inv_q}};
    {nib_c, nib_s} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
    res_next = res_q;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IW'(n)) res_next[4*n +: 4] = nib_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      idx   <= '0;
      carry <= 1'b0;
      inv_q <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        a_q   <= A;
        b_q   <= B;
        res_q <= '0;
        idx   <= '0;
        carry <= sub_sel;
        inv_q <= sub_sel;
      end else if (state == RUN) begin
        res_q <= res_next;
        carry <= nib_c;
        idx   <= idx + IW'(1);
        if (last) begin
          sum  <= res_next;
          cout <= nib_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - randomized and directed bench for nibble_serial_adder_ctrl
module tb_nibble_serial_adder_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sub_in;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SUBTRACT_EN
    .sub(sub_in),
`endif
    .A(A),
    .B(B),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sum(sum),
    .cout(cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: whole-word unsigned arithmetic, bit W is the carry out
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold, input bit intrude, input bit early);
    logic [W:0] exp;
    int n;
    exp = model(a, b, s);
    @(negedge clk);
    A = a; B = b; sub_in = s; in_valid = 1'b1; out_ready = early;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_run", 32'(busy), 32'd1);
    check("in_ready_run", 32'(in_ready), 32'd0);
    if (intrude) begin
      in_valid = 1'b1; A = 16'hAAAA; B = W'($urandom); sub_in = ~s;
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (!out_valid) check("in_ready_busy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; A = W'($urandom); B = W'($urandom);
    check("latency", 32'(n), 32'(NIBBLES));
    check("out_valid", 32'(out_valid), 32'd1);
    check("sum", 32'(sum), 32'(exp[W-1:0]));
    check("cout", 32'(cout), 32'(exp[W]));
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sum", 32'(sum), 32'(exp[W-1:0]));
        check("hold_cout", 32'(cout), 32'(exp[W]));
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("kept_sum", 32'(sum), 32'(exp[W-1:0]));
    check("kept_cout", 32'(cout), 32'(exp[W]));
  endtask

  initial begin
    rst_n = 1'b0; sub_in = 1'b0; A = '0; B = '0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_hold_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h0F0F, 16'hF0F1, 1'b0, 3, 1'b0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 1, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0, 1'b1);

    // reset pulse in the middle of RUN
    @(negedge clk);
    A = 16'h1111; B = 16'h2222; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_rearm", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst_no_result", 32'(out_valid), 32'd0);
    end
    run_op(16'hABCD, 16'h1111, 1'b0, 0, 1'b0, 1'b0);

`ifdef SUBTRACT_EN
    run_op(16'h0007, 16'h0005, 1'b1, 0, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 10; i++) begin
      logic s;
`ifdef SUBTRACT_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), s, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
